// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencing controller for the 5-stage RISC-V core. Produces the
//   per-stage write enables and flushes for PC, IF/ID, ID/EX, EX/MEM and
//   MEM/WB. It arbitrates between cache-miss freeze, load-use bubble and
//   taken-branch/jump redirect. Forwarding is handled elsewhere; this block
//   only covers the hazards forwarding cannot resolve.
//
//   Priority (highest first): rst > freeze > redirect > load_use > normal.
//
// Parameters
//   FLUSH_CYCLES : cycles IF_ID_flush is held after a redirect (1..3)
//   CNT_W        : width of the optional performance counters
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   IF_ID_rs1, IF_ID_rs2     : source registers of the instruction in ID
//   ID_EX_rd, ID_EX_memread  : destination / load flag of the instruction in EX
//   branch_taken             : EX resolved a taken branch or jump
//   icache_stall, dcache_stall : cache misses in progress
//   PC_write, PC_sel_target  : PC enable / PC takes the branch target
//   IF_ID_write, IF_ID_flush : IF/ID enable / load NOP
//   ID_EX_write, ID_EX_flush : ID/EX enable / load NOP (bubble)
//   EX_MEM_write, MEM_WB_write : later stage enables
//   cnt_freeze, cnt_loaduse, cnt_redirect : saturating event counters
//     (present only when HAZARD_PERF_CNT_EN is defined)
//
// Optional feature macro: HAZARD_PERF_CNT_EN
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_memread,
  input  logic       branch_taken,
  input  logic       icache_stall,
  input  logic       dcache_stall,
  output logic       PC_write,
  output logic       PC_sel_target,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_write,
  output logic       ID_EX_flush,
  output logic       EX_MEM_write,
  output logic       MEM_WB_write
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_freeze,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_redirect
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FREEZE   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       pend_redir_q, pend_redir_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;

  logic freeze_s;
  logic load_use_s;
  logic freeze_evt_s;
  logic loaduse_evt_s;
  logic redir_evt_s;

  assign freeze_s   = icache_stall | dcache_stall;
  assign load_use_s = ID_EX_memread & (ID_EX_rd != 5'd0) &
                      ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2));

  // State, pending-redirect flag and flush counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pend_redir_q <= 1'b0;
      flush_cnt_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      pend_redir_q <= pend_redir_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Next-state and stage controls, evaluated in priority order.
  always_comb begin
    state_d       = state_q;
    pend_redir_d  = pend_redir_q;
    flush_cnt_d   = flush_cnt_q;
    PC_write      = 1'b1;
    PC_sel_target = 1'b0;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_write  = 1'b1;
    MEM_WB_write  = 1'b1;
    freeze_evt_s  = 1'b0;
    loaduse_evt_s = 1'b0;
    redir_evt_s   = 1'b0;

    if (rst) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_write  = 1'b0;
      ID_EX_flush  = 1'b1;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      state_d      = RUN;
      pend_redir_d = 1'b0;
      flush_cnt_d  = 2'd0;
    end else if (freeze_s) begin
      // Whole pipe holds; a branch resolved now is remembered for later.
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      freeze_evt_s = 1'b1;
      state_d      = FREEZE;
      if (branch_taken) begin
        pend_redir_d = 1'b1;
      end else begin
        pend_redir_d = pend_redir_q;
      end
    end else if (state_q == REDIRECT) begin
      // Tail of a redirect: keep squashing whatever the I-cache delivers.
      // EX holds a bubble here, so branch_taken cannot legally be set.
      IF_ID_flush = 1'b1;
      flush_cnt_d = flush_cnt_q - 2'd1;
      if (flush_cnt_q <= 2'd1) begin
        state_d = RUN;
      end else begin
        state_d = REDIRECT;
      end
    end else if (branch_taken || pend_redir_q) begin
      // Redirect cycle; the ID instruction is squashed so load_use is moot.
      PC_sel_target = 1'b1;
      IF_ID_flush   = 1'b1;
      ID_EX_flush   = 1'b1;
      pend_redir_d  = 1'b0;
      redir_evt_s   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d     = REDIRECT;
        flush_cnt_d = 2'(FLUSH_CYCLES - 1);
      end else begin
        state_d     = RUN;
        flush_cnt_d = 2'd0;
      end
    end else if (load_use_s) begin
      // Single bubble; forwarding covers the remaining distance next cycle.
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_flush   = 1'b1;
      loaduse_evt_s = 1'b1;
      state_d       = RUN;
    end else begin
      state_d = RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_freeze_q;
  logic [CNT_W-1:0] cnt_loaduse_q;
  logic [CNT_W-1:0] cnt_redirect_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_freeze_q   <= {CNT_W{1'b0}};
      cnt_loaduse_q  <= {CNT_W{1'b0}};
      cnt_redirect_q <= {CNT_W{1'b0}};
    end else begin
      cnt_freeze_q   <= sat_inc(cnt_freeze_q, freeze_evt_s);
      cnt_loaduse_q  <= sat_inc(cnt_loaduse_q, loaduse_evt_s);
      cnt_redirect_q <= sat_inc(cnt_redirect_q, redir_evt_s);
    end
  end

  assign cnt_freeze   = cnt_freeze_q;
  assign cnt_loaduse  = cnt_loaduse_q;
  assign cnt_redirect = cnt_redirect_q;
`else
  logic unused_evt_s;
  assign unused_evt_s = freeze_evt_s ^ loaduse_evt_s ^ redir_evt_s;
`endif

endmodule
